// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 32;
   localparam int unsigned NRD_DEF    = 2;

   // Address width for a given depth; at least one bit so ports never collapse.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned ADDR_W_DEF = addr_width(DEPTH_DEF);

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks reserved destinations, grants reservations and
// keeps a registered count of busy registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned ADDR_W  = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic              res_valid,
   input  logic [ADDR_W-1:0] res_addr,
   output logic [DEPTH-1:0]  busy,
   output logic              res_ready,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   // True for addresses that own a real, trackable busy bit.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             wr_match;

   // Grant unless the target is busy and no write retires it this cycle.
   always_comb begin
      wr_match  = (we0 && (wa0 == res_addr)) || (we1 && (wa1 == res_addr));
      res_ready = !addr_ok(res_addr) || !busy_q[res_addr] || wr_match;
   end

   // Writes clear, accepted reservations set; the set is applied last so it wins.
   always_comb begin
      busy_d = busy_q;
      if (we0 && addr_ok(wa0)) busy_d[wa0] = 1'b0;
      if (we1 && addr_ok(wa1)) busy_d[wa1] = 1'b0;
      if (res_valid && res_ready && addr_ok(res_addr)) busy_d[res_addr] = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   // Scoreboard state and its popcount, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy     = busy_q;
   assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports, optional write-to-read
// bypass, hard-wired zero register and a destination busy scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned NRD      = NRD_DEF,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   localparam int unsigned ADDR_W  = addr_width(DEPTH)
) (
   input  logic                  Input_clk,
   input  logic                  Input_rst_n,
   input  logic [NRD*ADDR_W-1:0] Input_RA,
   output logic [NRD*DATA_W-1:0] monitor_read,
   output logic [NRD-1:0]        monitor_busy,
   input  logic                  Input_WE0,
   input  logic [ADDR_W-1:0]     Input_WA0,
   input  logic [DATA_W-1:0]     Input_WD0,
   input  logic                  Input_WE1,
   input  logic [ADDR_W-1:0]     Input_WA1,
   input  logic [DATA_W-1:0]     Input_WD1,
   input  logic                  Input_RES_valid,
   input  logic [ADDR_W-1:0]     Input_RES_addr,
   output logic                  monitor_RES_ready,
   output logic [ADDR_W:0]       monitor_busy_cnt
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   // True for addresses backed by writable storage.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [ADDR_W-1:0] ra;
   logic [DATA_W-1:0] rd;

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (Input_clk),
      .rst_n     (Input_rst_n),
      .we0       (Input_WE0),
      .wa0       (Input_WA0),
      .we1       (Input_WE1),
      .wa1       (Input_WA1),
      .res_valid (Input_RES_valid),
      .res_addr  (Input_RES_addr),
      .busy      (busy),
      .res_ready (monitor_RES_ready),
      .busy_cnt  (monitor_busy_cnt)
   );

   // Next storage contents; port 1 is applied last so it wins on a collision.
   always_comb begin
      mem_d = mem_q;
      if (Input_WE0 && addr_ok(Input_WA0)) mem_d[Input_WA0] = Input_WD0;
      if (Input_WE1 && addr_ok(Input_WA1)) mem_d[Input_WA1] = Input_WD1;
   end

   // Storage update with synchronous clear.
   always_ff @(posedge Input_clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!Input_rst_n) mem_q[i] <= '0;
         else              mem_q[i] <= mem_d[i];
      end
   end

   // Combinational read ports; invalid and zero addresses read 0 and never busy.
   always_comb begin
      monitor_read = '0;
      monitor_busy = '0;
      ra           = '0;
      rd           = '0;
      for (int k = 0; k < int'(NRD); k++) begin
         ra = Input_RA[k*ADDR_W +: ADDR_W];
         rd = '0;
         if (addr_ok(ra)) begin
            rd = mem_q[ra];
            if (BYPASS != 0) begin
               if (Input_WE0 && (Input_WA0 == ra)) rd = Input_WD0;
               if (Input_WE1 && (Input_WA1 == ra)) rd = Input_WD1;
            end
            monitor_busy[k] = busy[ra];
         end
         monitor_read[k*DATA_W +: DATA_W] = rd;
      end
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL take parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL take parameter DEPTH, default 32, number of registers; ADDR_W = clog2(DEPTH).
REQ-003 SHALL take parameter NRD, default 2, number of read ports.
REQ-004 SHALL take parameter ZERO_REG, default 1; when 1, register 0 reads zero and is never written or reserved.
REQ-005 SHALL take parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to reads.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 Input_clk  in  1  clock; all state updates on the rising edge.
REQ-008 Input_rst_n  in  1  synchronous active-low reset.
REQ-009 Input_RA  in  NRD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 monitor_read  out  NRD*DATA_W  packed read data, same packing.
REQ-011 monitor_busy  out  NRD  per read port, scoreboard busy bit of Input_RA[k].
REQ-012 Input_WE0 / Input_WA0 / Input_WD0  in  1 / ADDR_W / DATA_W  write port 0.
REQ-013 Input_WE1 / Input_WA1 / Input_WD1  in  1 / ADDR_W / DATA_W  write port 1.
REQ-014 Input_RES_valid / Input_RES_addr  in  1 / ADDR_W  reservation request marking a destination busy.
REQ-015 monitor_RES_ready  out  1  reservation accepted this cycle when valid and ready are both high.
REQ-016 monitor_busy_cnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-017 Reads SHALL be combinational: monitor_read[k] = reg[Input_RA[k]].
REQ-018 With BYPASS=1, a read SHALL return the write data when a WE on the same address is high that cycle; WD1 takes precedence over WD0.
REQ-019 With BYPASS=0, a read SHALL return the pre-edge register contents.
REQ-020 Writes SHALL take effect at the rising edge; if WE0 and WE1 target the same address, WD1 SHALL be stored.
REQ-021 With ZERO_REG=1, reads of address 0 SHALL return 0 (including bypass), writes to address 0 SHALL be ignored, and monitor_busy for address 0 SHALL be 0.
REQ-022 Any accepted write SHALL clear the busy bit of its address at the edge.
REQ-023 monitor_RES_ready SHALL be high when busy[RES_addr]=0 or a write to RES_addr is active that cycle; otherwise low (WAW stall).
REQ-024 An accepted reservation SHALL set busy[RES_addr] at the edge; if a write to the same address occurs in the same cycle, set SHALL win (busy stays 1).
REQ-025 A reservation of address 0 with ZERO_REG=1 SHALL be accepted (ready=1) and SHALL leave no busy bit set.
REQ-026 monitor_busy SHALL reflect pre-edge scoreboard state; no forwarding of same-cycle set/clear.
REQ-027 monitor_busy_cnt SHALL be registered and equal the popcount of the busy vector after each edge.
REQ-028 Addresses >= DEPTH (non-power-of-two DEPTH) SHALL read 0; writes and reservations to them SHALL be ignored, with ready=1.

Reset
REQ-029 While Input_rst_n=0 at an edge, all registers, all busy bits and monitor_busy_cnt SHALL become 0; writes and reservations that cycle SHALL be discarded.
REQ-030 After reset: monitor_read = 0 for all ports, monitor_busy = 0, monitor_RES_ready = 1, monitor_busy_cnt = 0.
REQ-031 Reset asserted mid-stall SHALL clear the stall; ready SHALL be 1 in the first cycle after release.

Structure
REQ-032 Package regfile_pkg SHALL hold the DATA_W/DEPTH/NRD defaults and the address/data width constants shared with regfile.
REQ-033 Scoreboard (busy vector, ready, popcount) SHALL be a sub-module named regfile_scoreboard; storage and bypass logic stay in the top level.

Verification
REQ-034 Reset, then write reg5=0xDEADBEEF via port 0 -> next cycle RA=5 reads 0xDEADBEEF; reg0 write of 0x1234 -> reads 0.
REQ-035 Same cycle WE0 to reg7=0x11 and WE1 to reg7=0x22 with RA=7, BYPASS=1 -> read 0x22 same cycle and after the edge.
REQ-036 Reserve reg3 -> busy[3]=1, busy_cnt=1; reserve reg3 again -> ready=0; write reg3 -> same cycle ready=1, next cycle busy[3]=0.
REQ-037 Same cycle: write reg9 and reserve reg9 (busy previously 0) -> after the edge busy[9]=1, data updated, busy_cnt=1.
REQ-038 Reserve regs 1..4, assert rst_n=0 for one cycle -> busy_cnt=0, all reads 0, ready=1.
REQ-039 NRD=4, DEPTH=20 build: four distinct simultaneous reads return correct data; RA=25 reads 0.
